// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between fetch and load/store,
// converting sub-word data accesses into aligned word accesses with byte enables.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifReq,
  input  logic [31:0]           ifAddr,
  output logic                  ifReady,
  output logic                  ifValid,
  output logic [31:0]           ifData,
  input  logic                  dReq,
  input  logic [31:0]           dAddr,
  input  logic                  dWrite,
  input  logic [1:0]            dSize,
  input  logic                  dUnsigned,
  input  logic [31:0]           dWData,
  output logic                  dReady,
  output logic                  dValid,
  output logic [31:0]           dRData,
  output logic                  dError,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWe,
  output logic [3:0]            memBe,
  output logic [31:0]           memWData,
  input  logic [31:0]           memRData
);

  localparam int unsigned CW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DATA_BURST);
  localparam logic [31:0] LO_MASK = (ADDR_WIDTH >= 32) ? '1 : ((32'd1 << ADDR_WIDTH) - 32'd1);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

  logic [CW-1:0] burst_cnt;
  logic          gnt_f, gnt_d, d_err;
  logic [1:0]    lane;

  owner_t        rsp_owner;
  logic          rsp_write, rsp_err, rsp_uns;
  logic [1:0]    rsp_size, rsp_lane;

  logic [31:0]   shifted, ld_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{ifAddr[31:ADDR_WIDTH], ifAddr[1:0]};
  assign lane = dAddr[1:0];

  // Grants are gated by rst so nothing reaches memory while held in reset.
  always_comb begin
    gnt_f = rst && ifReq && (!dReq || burst_cnt == BURST_MAX);
    gnt_d = rst && !gnt_f && dReq;
  end

  assign ifReady = gnt_f;
  assign dReady  = gnt_d;

  always_comb begin
    d_err = (dSize == 2'd3)
          | ((dSize == 2'd1) & dAddr[0])
          | ((dSize == 2'd2) & (|dAddr[1:0]))
          | (|(dAddr & ~LO_MASK));
  end

  always_comb begin
    memAddr  = '0;
    memWe    = 1'b0;
    memBe    = '0;
    memWData = '0;
    if (gnt_f) begin
      memAddr = {ifAddr[ADDR_WIDTH-1:2], 2'b00};
    end else if (gnt_d) begin
      memAddr = {dAddr[ADDR_WIDTH-1:2], 2'b00};
      if (!d_err) begin
        if (dWrite) begin
          memWe = 1'b1;
          case (dSize)
            2'd0: begin
              memBe    = 4'b0001 << lane;
              memWData = {4{dWData[7:0]}};
            end
            2'd1: begin
              memBe    = 4'b0011 << lane;
              memWData = {2{dWData[15:0]}};
            end
            default: begin
              memBe    = 4'hF;
              memWData = dWData;
            end
          endcase
        end else begin
          memBe = 4'hF;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (!ifReq || gnt_f) begin
      burst_cnt <= '0;
    end else if (gnt_d && burst_cnt != BURST_MAX) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_owner <= OWN_NONE;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_uns   <= 1'b0;
      rsp_size  <= '0;
      rsp_lane  <= '0;
    end else begin
      rsp_owner <= gnt_f ? OWN_FETCH : (gnt_d ? OWN_DATA : OWN_NONE);
      rsp_write <= dWrite;
      rsp_err   <= d_err;
      rsp_uns   <= dUnsigned;
      rsp_size  <= dSize;
      rsp_lane  <= lane;
    end
  end

  always_comb begin
    shifted = memRData >> {rsp_lane, 3'b000};
    case (rsp_size)
      2'd0:    ld_data = {{24{~rsp_uns & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_data = {{16{~rsp_uns & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  assign ifValid = (rsp_owner == OWN_FETCH);
  assign ifData  = ifValid ? memRData : '0;
  assign dValid  = (rsp_owner == OWN_DATA);
  assign dError  = dValid & rsp_err;
  assign dRData  = (dValid && !rsp_err && !rsp_write) ? ld_data : '0;

endmodule
